pipelined_mul_4to2_tree: RTL
============================

PIPELINED_MUL_4TO2_TREE -- requirements
Module: pipelined_mul_4to2_tree

Interface
REQ-001 Parameter DATA_LEN, default 8, operand width; SHALL be a power of two, 8..64.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operation offered.
REQ-006 in_ready  output  1  block accepts the operation this cycle.
REQ-007 op1, op2  input  DATA_LEN each  multiplicand and multiplier.
REQ-008 func3  input  3  RISC-V M-extension selector: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
REQ-009 in_tag  input  TAG_W  opaque tag.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 mul_result  output  DATA_LEN  selected half of the product.
REQ-013 mul_full  output  2*DATA_LEN  full product.
REQ-014 out_tag  output  TAG_W  tag of the returned operation.

Function
REQ-015 An operation SHALL transfer in on in_valid&&in_ready and out on out_valid&&out_ready.
REQ-016 Signedness SHALL be decoded from func3 as follows: 000/001 op1 and op2 signed; 010 op1 signed, op2 unsigned; 011 both unsigned; 1xx SHALL be treated as 000.
REQ-017 Partial products SHALL be generated with sign extension, with two's-complement weighting of the top row when op2 is signed.
REQ-018 Partial products SHALL be reduced by a 4:2-compressor tree to one sum vector and one carry vector, followed by a single final carry-propagate add.
REQ-019 The pipeline SHALL have three stages: S1 registers the qualified operands, signedness, func3 and tag; S2 registers the compressor-tree sum and carry vectors; S3 registers the final product and the selected half.
REQ-020 mul_result SHALL be product[DATA_LEN-1:0] for 000/1xx and product[2*DATA_LEN-1:DATA_LEN] for 001/010/011.
REQ-021 mul_full SHALL be the exact 2*DATA_LEN two's-complement product under the decoded signedness.
REQ-022 Latency SHALL be 3 cycles from acceptance to out_valid when no stall occurs.
REQ-023 Throughput SHALL be one operation per cycle.
REQ-024 Each stage SHALL hold a valid bit, and a stage SHALL advance when the next stage is empty or advancing, so bubbles collapse.
REQ-025 in_ready SHALL equal !s1_valid || s1_advance; this is combinational from out_ready.
REQ-026 While out_valid && !out_ready, mul_result, mul_full and out_tag SHALL hold stable; the pipeline SHALL fill to 3 entries and then deassert in_ready.
REQ-027 A simultaneous output drain and input accept with a full pipeline SHALL lose no operation and stall no cycle.
REQ-028 Results SHALL leave in acceptance order.
REQ-029 Data registers SHALL not update when their stage valid bit is not being loaded, to save power.

Reset
REQ-030 When rst_n is low, all valid bits SHALL clear asynchronously, and out_valid SHALL be 0 in the same cycle.
REQ-031 When rst_n is low, mul_result, mul_full and out_tag SHALL be 0.
REQ-032 When rst_n is low, the performance counter (if present) SHALL be 0.
REQ-033 Operations in flight at reset SHALL be discarded.
REQ-034 in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Configuration
REQ-035 With MUL_PERF_CNT_EN defined, the block SHALL add output perf_ops (32 bits), which increments on each output handshake and wraps from 0xFFFFFFFF to 0.
REQ-036 Without MUL_PERF_CNT_EN, the perf_ops port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification (DATA_LEN=8)
REQ-037 Sign edges: op1=0x80, op2=0x80 with func3=000 -> mul_full=0x4000, mul_result=0x00; with func3=001 -> mul_result=0x40, out_valid exactly 3 cycles after accept.
REQ-038 Mixed signedness: op1=op2=0xFF with func3=010 -> mul_full=0xFF01, mul_result=0xFF; with func3=011 -> mul_full=0xFE01, mul_result=0xFE; with func3=111 -> mul_result=0x01.
REQ-039 Backpressure: issue 5 back-to-back operations with tags 1..5 while out_ready=0 for 6 cycles -> in_ready drops after the 3rd accept; after release, tags emerge 1..5 in order with no loss and stable outputs while stalled.
REQ-040 Streaming: in_valid=1 and out_ready=1 for 100 random operations -> one result per cycle after the 3-cycle fill, all matching the reference model.
REQ-041 Reset mid-flight: assert rst_n=0 with 2 operations in flight -> out_valid=0 immediately, no stale result after release, and perf_ops=0 when MUL_PERF_CNT_EN is defined.
REQ-042 Counter wrap: with MUL_PERF_CNT_EN defined, force perf_ops=0xFFFFFFFE, then complete 2 handshakes -> perf_ops=0x00000000.

Source files
------------

// File: rtl/pipelined_mul_4to2_tree_if.sv
// -----------------------------------------------------------------------------
// pipelined_mul_4to2_tree_if
// Handshake bundle for the pipelined multiplier.
//   Request side : in_valid / in_ready, op1, op2, func3, in_tag
//   Response side: out_valid / out_ready, mul_result, mul_full, out_tag
// Modports:
//   master - the producer/consumer around the multiplier (drives requests,
//            drives out_ready, observes results)
//   slave  - the multiplier itself
// -----------------------------------------------------------------------------
interface pipelined_mul_4to2_tree_if #(
   parameter int DATA_LEN = 8,
   parameter int TAG_W    = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic [DATA_LEN-1:0]     op1;
   logic [DATA_LEN-1:0]     op2;
   logic [2:0]              func3;
   logic [TAG_W-1:0]        in_tag;
   logic                    out_valid;
   logic                    out_ready;
   logic [DATA_LEN-1:0]     mul_result;
   logic [2*DATA_LEN-1:0]   mul_full;
   logic [TAG_W-1:0]        out_tag;

   modport master (
      output in_valid, op1, op2, func3, in_tag, out_ready,
      input  in_ready, out_valid, mul_result, mul_full, out_tag
   );

   modport slave (
      input  in_valid, op1, op2, func3, in_tag, out_ready,
      output in_ready, out_valid, mul_result, mul_full, out_tag
   );
endinterface

// File: rtl/pipelined_mul_4to2_tree.sv
// -----------------------------------------------------------------------------
// pipelined_mul_4to2_tree
// Three-stage RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU) built from
// sign-extended partial products, a 4:2 compressor tree and one final
// carry-propagate adder.
//   S1: qualified operands, decoded signedness, func3, tag
//   S2: compressor-tree sum and carry vectors
//   S3: full product and selected half
// Ports:
//   clk      - sole clock, rising edge
//   rst_n    - asynchronous active-low reset, clears valid bits and outputs
//   bus      - pipelined_mul_4to2_tree_if.slave (valid/ready in and out)
//   perf_ops - 32-bit count of output handshakes, wraps (only when the
//              MUL_PERF_CNT_EN macro is defined)
// Parameters:
//   DATA_LEN - operand width, power of two 8..64
//   TAG_W    - sideband tag width
// -----------------------------------------------------------------------------
module pipelined_mul_4to2_tree #(
   parameter int DATA_LEN = 8,
   parameter int TAG_W    = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   pipelined_mul_4to2_tree_if.slave bus
`ifdef MUL_PERF_CNT_EN
   ,
   output logic [31:0]              perf_ops
`endif
);
   localparam int W      = 2 * DATA_LEN;
   // Rows are padded to a power of two so every tree level is a whole number
   // of 4:2 compressors; 2*DATA_LEN covers DATA_LEN rows plus the +1 row.
   localparam int P      = 2 * DATA_LEN;
   localparam int LEVELS = $clog2(P) - 1;

   // ---------------- stage registers ----------------
   logic                s1_valid_reg, s2_valid_reg, s3_valid_reg;
   logic [DATA_LEN-1:0] s1_op1_reg, s1_op2_reg;
   logic                s1_a_signed_reg, s1_b_signed_reg;
   logic [2:0]          s1_func3_reg, s2_func3_reg;
   logic [TAG_W-1:0]    s1_tag_reg, s2_tag_reg, s3_tag_reg;
   logic [W-1:0]        s2_sum_reg, s2_carry_reg;
   logic [W-1:0]        s3_full_reg;
   logic [DATA_LEN-1:0] s3_result_reg;

   // ---------------- flow control ----------------
   logic s3_free, s2_free, s1_free;
   logic s2_advance, s1_advance, accept;

   // A stage may load when it is empty or its occupant leaves this cycle, so
   // bubbles collapse and a full pipe still streams when the output drains.
   assign s3_free    = !s3_valid_reg || bus.out_ready;
   assign s2_advance = s2_valid_reg && s3_free;
   assign s2_free    = !s2_valid_reg || s2_advance;
   assign s1_advance = s1_valid_reg && s2_free;
   assign s1_free    = !s1_valid_reg || s1_advance;
   assign accept     = bus.in_valid && s1_free;

   assign bus.in_ready = s1_free;

   // ---------------- signedness decode ----------------
   logic a_signed_next, b_signed_next;

   always_comb begin
      a_signed_next = 1'b1;
      b_signed_next = 1'b1;
      case (bus.func3)
         3'b010:  b_signed_next = 1'b0;
         3'b011: begin
            a_signed_next = 1'b0;
            b_signed_next = 1'b0;
         end
         default: ;   // 000, 001 and all 1xx are signed x signed
      endcase
   end

   // ---------------- S1 ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg    <= 1'b0;
         s1_op1_reg      <= '0;
         s1_op2_reg      <= '0;
         s1_a_signed_reg <= 1'b0;
         s1_b_signed_reg <= 1'b0;
         s1_func3_reg    <= '0;
         s1_tag_reg      <= '0;
      end else begin
         if (s1_free)
            s1_valid_reg <= bus.in_valid;
         if (accept) begin
            s1_op1_reg      <= bus.op1;
            s1_op2_reg      <= bus.op2;
            s1_a_signed_reg <= a_signed_next;
            s1_b_signed_reg <= b_signed_next;
            s1_func3_reg    <= bus.func3;
            s1_tag_reg      <= bus.in_tag;
         end
      end
   end

   // ---------------- partial products + 4:2 tree ----------------
   logic [W-1:0] ext_a;
   logic         top_neg;

   assign ext_a   = {{DATA_LEN{s1_a_signed_reg & s1_op1_reg[DATA_LEN-1]}}, s1_op1_reg};
   // With a signed multiplier the top row weighs -2^(DATA_LEN-1): it is added
   // inverted and the +1 that completes the negation rides in its own row.
   assign top_neg = s1_b_signed_reg & s1_op2_reg[DATA_LEN-1];

   genvar gi;
   generate
      for (gi = 0; gi <= LEVELS; gi++) begin : g_lvl
         localparam int ROWS = P >> gi;
         logic [W-1:0] rows [0:ROWS-1];

         if (gi == 0) begin : g_pp
            for (genvar gj = 0; gj < ROWS; gj++) begin : g_row
               if (gj < DATA_LEN - 1) begin : g_plain
                  assign rows[gj] = s1_op2_reg[gj] ? (ext_a << gj) : '0;
               end else if (gj == DATA_LEN - 1) begin : g_top
                  assign rows[gj] = !s1_op2_reg[gj] ? '0 :
                                    (s1_b_signed_reg ? ~(ext_a << gj) : (ext_a << gj));
               end else if (gj == DATA_LEN) begin : g_corr
                  assign rows[gj] = {{(W-1){1'b0}}, top_neg};
               end else begin : g_zero
                  assign rows[gj] = '0;
               end
            end
         end else begin : g_cmp
            // Each 4:2 compressor is two chained carry-save rows; carries out
            // of bit W-1 are dropped since the product is taken modulo 2^W.
            for (genvar gj = 0; gj < ROWS / 2; gj++) begin : g_c42
               logic [W-1:0] a, b, c, d, s_mid, c_mid;
               assign a     = g_lvl[gi-1].rows[4*gj];
               assign b     = g_lvl[gi-1].rows[4*gj+1];
               assign c     = g_lvl[gi-1].rows[4*gj+2];
               assign d     = g_lvl[gi-1].rows[4*gj+3];
               assign s_mid = a ^ b ^ c;
               assign c_mid = ((a & b) | (a & c) | (b & c)) << 1;
               assign rows[2*gj]   = s_mid ^ d ^ c_mid;
               assign rows[2*gj+1] = ((s_mid & d) | (s_mid & c_mid) | (d & c_mid)) << 1;
            end
         end
      end
   endgenerate

   // ---------------- S2 ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_reg <= 1'b0;
         s2_sum_reg   <= '0;
         s2_carry_reg <= '0;
         s2_func3_reg <= '0;
         s2_tag_reg   <= '0;
      end else begin
         if (s2_free)
            s2_valid_reg <= s1_valid_reg;
         if (s1_advance) begin
            s2_sum_reg   <= g_lvl[LEVELS].rows[0];
            s2_carry_reg <= g_lvl[LEVELS].rows[1];
            s2_func3_reg <= s1_func3_reg;
            s2_tag_reg   <= s1_tag_reg;
         end
      end
   end

   // ---------------- final add + half select ----------------
   logic [W-1:0] product;
   logic         hi_sel;

   assign product = s2_sum_reg + s2_carry_reg;
   // MULH/MULHSU/MULHU return the upper half; MUL and every 1xx the lower.
   assign hi_sel  = !s2_func3_reg[2] && (s2_func3_reg[1:0] != 2'b00);

   // ---------------- S3 ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_valid_reg  <= 1'b0;
         s3_full_reg   <= '0;
         s3_result_reg <= '0;
         s3_tag_reg    <= '0;
      end else begin
         if (s3_free)
            s3_valid_reg <= s2_valid_reg;
         if (s2_advance) begin
            s3_full_reg   <= product;
            s3_result_reg <= hi_sel ? product[W-1:DATA_LEN] : product[DATA_LEN-1:0];
            s3_tag_reg    <= s2_tag_reg;
         end
      end
   end

   assign bus.out_valid  = s3_valid_reg;
   assign bus.mul_full   = s3_full_reg;
   assign bus.mul_result = s3_result_reg;
   assign bus.out_tag    = s3_tag_reg;

`ifdef MUL_PERF_CNT_EN
   logic [31:0] perf_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         perf_cnt_reg <= '0;
      else if (s3_valid_reg && bus.out_ready)
         perf_cnt_reg <= perf_cnt_reg + 32'd1;
   end

   assign perf_ops = perf_cnt_reg;
`endif

endmodule
